// File: rtl/instr_control_if.sv
// Bundles the CPU-side fetch/decode signals between instr_control and the ROM/ALU/register-file environment.
interface instr_control_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [8:0]       InstrIn;
    logic [7:0]       RegDataIn;
    logic             ConditionalBranch;
    logic [PC_W-1:0]  InstrAddr;
    logic             Type;
    logic [3:0]       RTypeOP;
    logic [2:0]       ITypeOP;
    logic [4:0]       ImmediateIn;
    logic [3:0]       RegSel;
    logic             AccWrite;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;

    modport master (
        input  Start, InstrIn, RegDataIn, ConditionalBranch,
        output InstrAddr, Type, RTypeOP, ITypeOP, ImmediateIn, RegSel,
               AccWrite, RegWrite, MemRead, MemWrite, Done, CycleCount
    );

    modport slave (
        output Start, InstrIn, RegDataIn, ConditionalBranch,
        input  InstrAddr, Type, RTypeOP, ITypeOP, ImmediateIn, RegSel,
               AccWrite, RegWrite, MemRead, MemWrite, Done, CycleCount
    );
endinterface

// File: rtl/instr_control.sv
// Fetch/decode/sequence unit for the accumulator CPU: decode and strobes are combinational in the
// same cycle as the fetched word; one instruction per cycle except LOAD (two); no backpressure.
module instr_control #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    instr_control_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] R_LOAD = 4'd1;
    localparam logic [3:0] R_MVTO = 4'd3;
    localparam logic [3:0] R_STR  = 4'd8;
    localparam logic [3:0] R_BTRU = 4'd11;
    localparam logic [2:0] I_B    = 3'd3;
    localparam logic [2:0] I_HALT = 3'd7;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc, pc_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PC_W-1:0]   off_reg, off_imm;

    // Offsets are sign-extended into PC width so the add wraps modulo 2^PC_W.
    assign off_reg = PC_W'($signed(bus.RegDataIn));
    assign off_imm = PC_W'($signed(bus.InstrIn[4:0]));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        cnt_nxt         = cnt;
        bus.Type        = 1'b0;
        bus.RTypeOP     = '0;
        bus.ITypeOP     = '0;
        bus.ImmediateIn = '0;
        bus.RegSel      = '0;
        bus.AccWrite    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;

        if (state == S_EXEC || state == S_MEM) begin
            bus.Type        = bus.InstrIn[8];
            bus.RTypeOP     = bus.InstrIn[7:4];
            bus.ITypeOP     = bus.InstrIn[7:5];
            bus.ImmediateIn = bus.InstrIn[4:0];
            bus.RegSel      = bus.InstrIn[3:0];
            cnt_nxt         = (&cnt) ? cnt : cnt + CNT_W'(1);
        end

        case (state)
            S_IDLE, S_HALT: begin
                if (bus.Start) begin
                    state_nxt = S_EXEC;
                    pc_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
            S_EXEC: begin
                pc_nxt = pc + PC_W'(1);
                if (bus.InstrIn[8]) begin
                    case (bus.InstrIn[7:4])
                        4'd0, 4'd4, 4'd5, 4'd6, 4'd7,
                        4'd9, 4'd10, 4'd12, 4'd13: bus.AccWrite = 1'b1;
                        R_LOAD: begin
                            bus.MemRead = 1'b1;
                            pc_nxt      = pc;
                            state_nxt   = S_MEM;
                        end
                        R_MVTO: bus.RegWrite = 1'b1;
                        R_STR:  bus.MemWrite = 1'b1;
                        R_BTRU: if (bus.ConditionalBranch) pc_nxt = pc + off_reg;
                        default: ;
                    endcase
                end else begin
                    case (bus.InstrIn[7:5])
                        3'd1, 3'd2, 3'd4, 3'd5: bus.AccWrite = 1'b1;
                        I_B:    pc_nxt = pc + off_imm;
                        I_HALT: begin
                            pc_nxt    = pc;
                            state_nxt = S_HALT;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                bus.AccWrite = 1'b1;
                bus.MemRead  = 1'b1;
                pc_nxt       = pc + PC_W'(1);
                state_nxt    = S_EXEC;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.InstrAddr  = pc;
    assign bus.CycleCount = cnt;
    assign bus.Done       = (state == S_HALT);
endmodule

// File: tb/tb_instr_control.sv
// Directed bench for instr_control: behavioural ROM, hand-computed expectations per cycle.
module tb_instr_control;
    logic Clk;
    logic Reset;
    int   checks;
    int   failures;
    logic [8:0] rom [0:1023];

    instr_control_if #(.PC_W(10), .CNT_W(16)) bus ();

    instr_control #(.PC_W(10), .CNT_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.InstrIn = rom[bus.InstrAddr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 1024; i++) rom[i] = 9'h0E0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        bus.Start = 1'b0;
        bus.ConditionalBranch = 1'b0;
        bus.RegDataIn = 8'h00;
        fill_halt();
        rom[0] = 9'h025;
        rom[1] = 9'h0E0;
        #2;
        chk("rst_addr",  32'(bus.InstrAddr), 0);
        chk("rst_done",  32'(bus.Done), 0);
        chk("rst_cnt",   32'(bus.CycleCount), 0);
        chk("rst_iop",   32'(bus.ITypeOP), 0);
        chk("rst_imm",   32'(bus.ImmediateIn), 0);
        chk("rst_acc",   32'(bus.AccWrite), 0);
        tick();
        Reset = 1'b0;
        tick();
        chk("idle_addr", 32'(bus.InstrAddr), 0);

        // ADDI 5 then HALT
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        #1;
        chk("addi_iop",  32'(bus.ITypeOP), 1);
        chk("addi_imm",  32'(bus.ImmediateIn), 5);
        chk("addi_acc",  32'(bus.AccWrite), 1);
        chk("addi_type", 32'(bus.Type), 0);
        tick();
        chk("halt_iop",  32'(bus.ITypeOP), 7);
        chk("halt_acc",  32'(bus.AccWrite), 0);
        chk("halt_cnt1", 32'(bus.CycleCount), 1);
        tick();
        chk("t1_done",   32'(bus.Done), 1);
        chk("t1_addr",   32'(bus.InstrAddr), 1);
        chk("t1_cnt",    32'(bus.CycleCount), 2);
        chk("t1_iop0",   32'(bus.ITypeOP), 0);

        // LOAD r2 then HALT
        rom[0] = 9'h112;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        #1;
        chk("ld_done0",  32'(bus.Done), 0);
        chk("ld_cnt0",   32'(bus.CycleCount), 0);
        chk("ld_rd1",    32'(bus.MemRead), 1);
        chk("ld_acc1",   32'(bus.AccWrite), 0);
        chk("ld_sel",    32'(bus.RegSel), 2);
        chk("ld_pc1",    32'(bus.InstrAddr), 0);
        tick();
        chk("ld_rd2",    32'(bus.MemRead), 1);
        chk("ld_acc2",   32'(bus.AccWrite), 1);
        chk("ld_pc2",    32'(bus.InstrAddr), 0);
        chk("ld_sel2",   32'(bus.RegSel), 2);
        tick();
        chk("ld_pc3",    32'(bus.InstrAddr), 1);
        chk("ld_rd3",    32'(bus.MemRead), 0);
        tick();
        chk("ld_done",   32'(bus.Done), 1);
        chk("ld_cnt",    32'(bus.CycleCount), 3);

        // B +4, then B -3 back to 1
        rom[0] = 9'h064;
        rom[4] = 9'h07D;
        bus.ConditionalBranch = 1'b0;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        chk("b_fwd",     32'(bus.InstrAddr), 4);
        tick();
        chk("b_back",    32'(bus.InstrAddr), 1);
        tick();
        chk("b_done",    32'(bus.Done), 1);
        chk("b_cnt",     32'(bus.CycleCount), 3);

        // B -1 at PC 0 wraps to 1023
        fill_halt();
        rom[0] = 9'h07F;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        chk("wrap_pc",   32'(bus.InstrAddr), 1023);
        tick();
        chk("wrap_done", 32'(bus.Done), 1);
        chk("wrap_hold", 32'(bus.InstrAddr), 1023);

        // BTRU r3 with offset -2, taken then not taken; NOPs see a stale ConditionalBranch
        fill_halt();
        rom[0] = 9'h0C0;
        rom[1] = 9'h0C0;
        rom[2] = 9'h1B3;
        bus.RegDataIn = 8'hFE;
        bus.ConditionalBranch = 1'b1;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        chk("nop_cb_pc", 32'(bus.InstrAddr), 1);
        tick();
        chk("btru_pc",   32'(bus.InstrAddr), 2);
        chk("btru_sel",  32'(bus.RegSel), 3);
        chk("btru_rop",  32'(bus.RTypeOP), 11);
        chk("btru_acc",  32'(bus.AccWrite), 0);
        tick();
        chk("btru_tkn",  32'(bus.InstrAddr), 0);
        bus.ConditionalBranch = 1'b0;
        tick();
        tick();
        tick();
        chk("btru_ntkn", 32'(bus.InstrAddr), 3);
        tick();
        chk("btru_done", 32'(bus.Done), 1);

        // STR, MVTO r5, R-type op12, R-type NOP, HALT
        fill_halt();
        rom[0] = 9'h180;
        rom[1] = 9'h135;
        rom[2] = 9'h1C4;
        rom[3] = 9'h120;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        #1;
        chk("str_wr",    32'(bus.MemWrite), 1);
        chk("str_rd",    32'(bus.MemRead), 0);
        chk("str_acc",   32'(bus.AccWrite), 0);
        tick();
        chk("mvto_rw",   32'(bus.RegWrite), 1);
        chk("mvto_sel",  32'(bus.RegSel), 5);
        chk("mvto_wr",   32'(bus.MemWrite), 0);
        tick();
        chk("r12_acc",   32'(bus.AccWrite), 1);
        chk("r12_rw",    32'(bus.RegWrite), 0);
        tick();
        chk("rnop_strb", 32'({bus.AccWrite, bus.RegWrite, bus.MemRead, bus.MemWrite}), 0);
        tick();
        tick();
        chk("seq_done",  32'(bus.Done), 1);
        chk("seq_addr",  32'(bus.InstrAddr), 4);
        chk("seq_cnt",   32'(bus.CycleCount), 5);

        // Start ignored in EXEC; reset during the MEM cycle of a LOAD
        fill_halt();
        rom[0] = 9'h0C0;
        rom[1] = 9'h112;
        bus.Start = 1'b1;
        tick();
        tick();
        chk("st_ign_pc", 32'(bus.InstrAddr), 1);
        bus.Start = 1'b0;
        #1;
        chk("mr_exec",   32'(bus.MemRead), 1);
        tick();
        chk("mr_mem",    32'(bus.AccWrite), 1);
        Reset = 1'b1;
        #1;
        chk("ar_rd",     32'(bus.MemRead), 0);
        chk("ar_acc",    32'(bus.AccWrite), 0);
        chk("ar_addr",   32'(bus.InstrAddr), 0);
        chk("ar_done",   32'(bus.Done), 0);
        chk("ar_cnt",    32'(bus.CycleCount), 0);
        #1;
        Reset = 1'b0;
        tick();
        chk("ar_idle",   32'(bus.InstrAddr), 0);
        chk("ar_idle_r", 32'(bus.Type), 0);

        // HALT restart with a pulse, then with Start held
        fill_halt();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        chk("h_done",    32'(bus.Done), 1);
        chk("h_cnt",     32'(bus.CycleCount), 1);
        bus.Start = 1'b1;
        tick();
        chk("rs_done",   32'(bus.Done), 0);
        chk("rs_cnt",    32'(bus.CycleCount), 0);
        chk("rs_addr",   32'(bus.InstrAddr), 0);
        tick();
        chk("held_done", 32'(bus.Done), 1);
        tick();
        chk("held_rs",   32'(bus.Done), 0);
        bus.Start = 1'b0;
        tick();
        chk("held_end",  32'(bus.Done), 1);

        // B 0 spins in place; CycleCount saturates
        rom[0] = 9'h060;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        repeat (65540) @(posedge Clk);
        #1;
        chk("spin_pc",   32'(bus.InstrAddr), 0);
        chk("sat_cnt",   32'(bus.CycleCount), 32'hFFFF);
        chk("spin_done", 32'(bus.Done), 0);
        Reset = 1'b1;
        #2;
        Reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_control.md
Name: instr_control

Overview:
- Fetch/decode/sequence unit for the accumulator CPU.
- Drives the instruction ROM address and decodes each 9-bit instruction into the field and opcode signals the ALU consumes: Type, RTypeOP, ITypeOP, ImmediateIn.
- Generates the register-file and data-memory strobes.
- Sequences the PC, including branches resolved by the ALU's ConditionalBranch.
- Provides the Start/Done program handshake and a cycle counter.

Parameters:
PC_W, 10, program counter width (ROM depth 2^PC_W; PC wraps modulo 2^PC_W)
CNT_W, 16, cycle counter width (saturates at all-ones)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  begin program at PC=0 (sampled in IDLE or HALT only)
InstrIn  input  9  instruction word from combinational ROM at InstrAddr
RegDataIn  input  8  register-file read data for RegSel (BTRU offset)
ConditionalBranch  input  1  branch-taken flag from ALU, same cycle
InstrAddr  output  PC_W  current PC
Type  output  1  InstrIn[8]; 1=R-type
RTypeOP  output  4  InstrIn[7:4]
ITypeOP  output  3  InstrIn[7:5]
ImmediateIn  output  5  InstrIn[4:0]
RegSel  output  4  InstrIn[3:0], register index for R-type
AccWrite  output  1  write ALU Out into accumulator this cycle
RegWrite  output  1  write accumulator into RegSel (MVTO)
MemRead  output  1  data-memory read
MemWrite  output  1  data-memory write (STR)
Done  output  1  high while in HALT
CycleCount  output  CNT_W  cycles spent in EXEC+MEM for the last or current run

Behaviour:
- Reset:
  - State = IDLE, PC = 0, CycleCount = 0.
  - All strobes, Done and decoded fields are 0.
  - Reset mid-run aborts immediately; no strobe survives the reset edge.
- States:
  - IDLE: on Start -> EXEC, PC = 0, CycleCount = 0.
  - EXEC: decode InstrIn combinationally and assert strobes in the same cycle. On the clock edge, update the PC per the rules below.
    - LOAD -> MEM.
    - HALT -> HALT.
    - Otherwise stay in EXEC.
  - MEM: assert AccWrite, hold MemRead high; PC = PC+1; -> EXEC.
  - HALT: Done = 1, PC held. Start -> EXEC with PC = 0 and CycleCount cleared.
- Decoded fields:
  - Driven from InstrIn only in EXEC and MEM; forced to 0 in IDLE and HALT.
  - In MEM, the fields still reflect the LOAD word (PC is held).
- R-type opcodes:
  - AccWrite: 0, 4, 5, 6, 7, 9, 10, 12, 13.
  - LOAD (1): MemRead in EXEC and MEM; AccWrite in MEM only; 2 cycles total.
  - MVTO (3): RegWrite.
  - STR (8): MemWrite for one cycle.
  - BTRU (11): if ConditionalBranch, PC = PC + sext8(RegDataIn); else PC+1.
  - Opcodes 2, 14, 15: NOP.
- I-type opcodes:
  - ADDI (1), SUBI (2), LSLI (4), LSRI (5): AccWrite.
  - B (3): PC = PC + sext5(ImmediateIn), taken unconditionally; ConditionalBranch is ignored.
  - HALT (7): no strobes; -> HALT.
  - Opcodes 0, 6: NOP.
- ConditionalBranch is sampled only for BTRU and ignored otherwise (the ALU may leave it stale).
- PC arithmetic:
  - Modulo 2^PC_W; the sign-extended offset is added in PC_W bits.
  - Wrap from max to 0 is legal.
  - Branch offset 0 spins on the same instruction.
- Start:
  - Ignored in EXEC and MEM.
  - Start held high in HALT restarts once per rising into EXEC; a continuously held Start after HALT restarts again.
- CycleCount:
  - Increments every cycle in EXEC or MEM, including the HALT instruction cycle.
  - Saturates at all-ones.
  - Holds its value in HALT.
- Exclusivity: at most one of AccWrite/RegWrite/MemWrite is high per cycle; MemRead and MemWrite are never both high.

Test Plan:
- Reset, Start; ROM[0]=0x025 (ADDI 5), ROM[1]=0x0E0 (HALT) -> cycle1: ITypeOP=1, ImmediateIn=5, AccWrite=1; cycle2: HALT decoded; then Done=1, InstrAddr=1, CycleCount=2.
- ROM[0]=0x112 (LOAD r2), ROM[1]=0x0E0 -> MemRead=1 for 2 cycles, AccWrite only in the 2nd cycle, RegSel=2, PC holds 0 then 1; CycleCount=3 at Done.
- ROM[4]=0x07D (B -3) -> next InstrAddr=1; ROM[0]=0x07F (B -1) at PC=0 -> InstrAddr wraps to 1023.
- ROM[2]=0x1B3 (BTRU r3), RegDataIn=0xFE: with ConditionalBranch=1 -> next PC=0; with ConditionalBranch=0 -> PC=3. I-type NOP with ConditionalBranch=1 -> PC+1.
- Assert Reset during MEM of a LOAD -> asynchronously MemRead=0, AccWrite=0, InstrAddr=0, Done=0; Start pulses while in EXEC are ignored (PC unaffected).
- In HALT, pulse Start -> EXEC at PC=0, CycleCount restarts from 0, Done drops the following cycle.
